dmem_mmio: RTL and testbench

Data-side memory subsystem that sits directly downstream of the CPU core's MEM stage and services its DMEM port. It provides a doubleword RAM, an 8-bit transmit FIFO with a valid/ready drain port, and a 64-bit machine timer with a compare interrupt, all in one flat address map. Reads are combinational so the core can latch `DMEM_ReadData` into MEM/WB at the same edge. Writes commit on the rising clock edge.

---
 rtl/dmem_mmio_if.sv | 29 ++
 rtl/dmem_mmio.sv | 126 ++++++++++++
 tb/tb_dmem_mmio.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_if.sv
//------------------------------------------------------------------------------
// dmem_mmio_if : core DMEM bus plus TX drain stream and timer interrupt
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_mmio_if;
  logic [63:0] DMEM_address;
  logic [63:0] DMEM_WriteData;
  logic        DMEM_MemWrite;
  logic        DMEM_MemRead;
  logic [63:0] DMEM_ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  modport master (
    output DMEM_address, DMEM_WriteData, DMEM_MemWrite, DMEM_MemRead, tx_ready,
    input  DMEM_ReadData, tx_data, tx_valid, timer_irq
  );

  modport slave (
    input  DMEM_address, DMEM_WriteData, DMEM_MemWrite, DMEM_MemRead, tx_ready,
    output DMEM_ReadData, tx_data, tx_valid, timer_irq
  );
endinterface

`default_nettype wire

// File: rtl/dmem_mmio.sv
//------------------------------------------------------------------------------
// dmem_mmio : doubleword RAM, TX byte FIFO and 64-bit machine timer, flat map
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_mmio #(
  parameter int          RAM_WORDS  = 512,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [63:0] MMIO_BASE  = 64'h0000_0000_1000_0000
) (
  input  wire logic clk,
  input  wire logic rst,
  dmem_mmio_if.slave bus
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [63:0] RAM_BYTES = 64'(RAM_WORDS) * 64'd8;
  localparam logic [1:0]  REG_TXDATA   = 2'd0;
  localparam logic [1:0]  REG_STATUS   = 2'd1;
  localparam logic [1:0]  REG_MTIME    = 2'd2;
  localparam logic [1:0]  REG_MTIMECMP = 2'd3;

  logic [63:0]   r_mem [RAM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [63:0]   r_mtime, r_mtimecmp;
  logic          r_irq;

  logic [63:0]   w_mmio_off;
  logic          w_ram_hit, w_mmio_hit;
  logic [1:0]    w_reg;
  logic [AW-1:0] w_ram_idx;
  logic          w_reg_wr_tx, w_reg_wr_st, w_reg_wr_mt, w_reg_wr_cmp;
  logic          w_empty, w_full, w_pop, w_push, w_ovf_set, w_ovf_clr;
  logic [63:0]   w_status, w_rdata;

  // Offset subtraction wraps for addresses below the base, so one unsigned compare bounds the window.
  assign w_mmio_off = bus.DMEM_address - MMIO_BASE;
  assign w_ram_hit  = bus.DMEM_address < RAM_BYTES;
  assign w_mmio_hit = w_mmio_off < 64'h20;
  assign w_reg      = w_mmio_off[4:3];
  assign w_ram_idx  = bus.DMEM_address[3 +: AW];

  assign w_reg_wr_tx  = bus.DMEM_MemWrite && w_mmio_hit && (w_reg == REG_TXDATA);
  assign w_reg_wr_st  = bus.DMEM_MemWrite && w_mmio_hit && (w_reg == REG_STATUS);
  assign w_reg_wr_mt  = bus.DMEM_MemWrite && w_mmio_hit && (w_reg == REG_MTIME);
  assign w_reg_wr_cmp = bus.DMEM_MemWrite && w_mmio_hit && (w_reg == REG_MTIMECMP);

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = !w_empty && bus.tx_ready;
  assign w_push    = w_reg_wr_tx && (!w_full || w_pop);
  assign w_ovf_set = w_reg_wr_tx && !w_push;
  assign w_ovf_clr = w_reg_wr_st && bus.DMEM_WriteData[2];
  assign w_status  = {48'b0, 8'(r_count), 5'b0, r_ovf, w_empty, w_full};

  always_comb begin
    w_rdata = '0;
    if (bus.DMEM_MemRead) begin
      if (w_ram_hit) begin
        w_rdata = r_mem[w_ram_idx];
      end else if (w_mmio_hit) begin
        case (w_reg)
          REG_STATUS:   w_rdata = w_status;
          REG_MTIME:    w_rdata = r_mtime;
          REG_MTIMECMP: w_rdata = r_mtimecmp;
          default:      w_rdata = '0;
        endcase
      end
    end
  end

  assign bus.DMEM_ReadData = w_rdata;
  assign bus.tx_data       = r_fifo[r_rd_ptr];
  assign bus.tx_valid      = !w_empty;
  assign bus.timer_irq     = r_irq;

  // Storage arrays carry no reset; their contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (bus.DMEM_MemWrite && w_ram_hit) begin
      r_mem[w_ram_idx] <= bus.DMEM_WriteData;
    end
    if (w_push) begin
      r_fifo[r_wr_ptr] <= bus.DMEM_WriteData[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_irq      <= 1'b0;
    end else begin
      r_mtime <= w_reg_wr_mt ? bus.DMEM_WriteData : r_mtime + 64'd1;
      if (w_reg_wr_cmp) r_mtimecmp <= bus.DMEM_WriteData;
      r_irq <= (r_mtime >= r_mtimecmp);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_mmio.sv
//------------------------------------------------------------------------------
// tb_dmem_mmio : directed self-checking bench for dmem_mmio
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_mmio;

  localparam logic [63:0] BASE   = 64'h0000_0000_1000_0000;
  localparam logic [63:0] A_TX   = BASE + 64'h00;
  localparam logic [63:0] A_ST   = BASE + 64'h08;
  localparam logic [63:0] A_MT   = BASE + 64'h10;
  localparam logic [63:0] A_CMP  = BASE + 64'h18;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;

  dmem_mmio_if bus ();

  dmem_mmio #(
    .RAM_WORDS (512),
    .FIFO_DEPTH(8),
    .MMIO_BASE (BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] data);
    bus.DMEM_address   = addr;
    bus.DMEM_WriteData = data;
    bus.DMEM_MemWrite  = 1'b1;
    tick();
    bus.DMEM_MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [63:0] addr, output logic [63:0] data);
    bus.DMEM_address  = addr;
    bus.DMEM_MemRead  = 1'b1;
    #1;
    data = bus.DMEM_ReadData;
    bus.DMEM_MemRead  = 1'b0;
  endtask

  logic [63:0] v;
  logic [63:0] mt_exp;

  initial begin
    n_compared         = 0;
    n_mismatched       = 0;
    rst                = 1'b1;
    bus.DMEM_address   = '0;
    bus.DMEM_WriteData = '0;
    bus.DMEM_MemWrite  = 1'b0;
    bus.DMEM_MemRead   = 1'b0;
    bus.tx_ready       = 1'b0;

    #2;
    check("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    check("rst_irq", 64'(bus.timer_irq), 64'd0);
    check("rst_rdata", bus.DMEM_ReadData, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // RAM access
    wr(64'h40, 64'hDEAD_BEEF_CAFE_F00D);
    wr(64'h48, 64'h0123_4567_89AB_CDEF);
    rd(64'h40, v); check("ram_0x40", v, 64'hDEAD_BEEF_CAFE_F00D);
    rd(64'h48, v); check("ram_0x48", v, 64'h0123_4567_89AB_CDEF);
    rd(64'h44, v); check("ram_lowbits", v, 64'hDEAD_BEEF_CAFE_F00D);
    bus.DMEM_address = 64'h40;
    #1;
    check("ram_noread", bus.DMEM_ReadData, 64'd0);
    rd(64'h2000_0000, v); check("unmapped", v, 64'd0);
    tick();
    bus.DMEM_address   = 64'h40;
    bus.DMEM_WriteData = 64'h1111_2222_3333_4444;
    bus.DMEM_MemWrite  = 1'b1;
    bus.DMEM_MemRead   = 1'b1;
    #1;
    check("rw_prewrite", bus.DMEM_ReadData, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    bus.DMEM_MemWrite = 1'b0;
    bus.DMEM_MemRead  = 1'b0;
    rd(64'h40, v); check("rw_postwrite", v, 64'h1111_2222_3333_4444);
    tick();

    // FIFO fill and overflow
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) wr(A_TX, 64'(i));
    rd(A_ST, v); check("status_full_ovf", v, 64'h805);
    rd(A_TX, v); check("txdata_read", v, 64'd0);
    tick();
    bus.tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_valid", 64'(bus.tx_valid), 64'd1);
      check("drain_data", 64'(bus.tx_data), 64'(i));
      tick();
    end
    bus.tx_ready = 1'b0;
    check("drained_valid", 64'(bus.tx_valid), 64'd0);
    rd(A_ST, v); check("status_empty_ovf", v, 64'h006);
    tick();
    wr(A_ST, 64'd4);
    rd(A_ST, v); check("status_ovf_clr", v, 64'h002);
    tick();

    // Full push + pop in the same cycle
    for (int i = 0; i < 8; i++) wr(A_TX, 64'h11 + 64'(i));
    rd(A_ST, v); check("status_full", v, 64'h801);
    tick();
    bus.tx_ready = 1'b1;
    wr(A_TX, 64'hAA);
    bus.tx_ready = 1'b0;
    rd(A_ST, v); check("status_pushpop", v, 64'h801);
    tick();
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pp_drain_data", 64'(bus.tx_data), (i == 7) ? 64'hAA : 64'h12 + 64'(i));
      tick();
    end
    bus.tx_ready = 1'b0;
    check("pp_drained_valid", 64'(bus.tx_valid), 64'd0);

    // Timer compare
    wr(A_MT, 64'd100);
    rd(A_MT, v); check("mtime_load", v, 64'd100);
    wr(A_CMP, 64'd105);
    rd(A_CMP, v); check("mtimecmp_rd", v, 64'd105);
    for (mt_exp = 64'd101; mt_exp <= 64'd108; mt_exp++) begin
      rd(A_MT, v); check("mtime_count", v, mt_exp);
      check("irq_vs_prev", 64'(bus.timer_irq), (mt_exp - 64'd1 >= 64'd105) ? 64'd1 : 64'd0);
      tick();
    end
    wr(A_CMP, '1);
    check("irq_lag_hold", 64'(bus.timer_irq), 64'd1);
    tick();
    check("irq_fall", 64'(bus.timer_irq), 64'd0);

    // Timer wrap
    wr(A_MT, 64'hFFFF_FFFF_FFFF_FFFE);
    rd(A_MT, v); check("wrap_fffe", v, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    rd(A_MT, v); check("wrap_ffff", v, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    rd(A_MT, v); check("wrap_zero", v, 64'd0);
    tick();

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) wr(A_TX, 64'h50 + 64'(i));
    wr(A_CMP, 64'd0);
    tick();
    check("pre_rst_irq", 64'(bus.timer_irq), 64'd1);
    check("pre_rst_valid", 64'(bus.tx_valid), 64'd1);
    rd(A_ST, v); check("pre_rst_status", v, 64'h300);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.tx_valid), 64'd0);
    check("async_rst_irq", 64'(bus.timer_irq), 64'd0);
    rd(A_ST, v); check("async_rst_status", v, 64'h002);
    #1;
    rst = 1'b0;
    rd(A_MT, v); check("post_rst_mtime", v, 64'd0);
    rd(A_CMP, v); check("post_rst_cmp", v, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
